// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types for the four-way round-robin mux arbiter.
// Holds the requester index type, the output-stage state encoding and a one-hot helper.
package rr_mux_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] src_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot4(input src_t idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4.sv
// Generic registered-free 4:1 data mux shared by arbitration blocks.
// sel picks which of the four input words is driven onto y.
module mux4 #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a0;
    unique case (sel)
      2'd0: y = a0;
      2'd1: y = a1;
      2'd2: y = a2;
      2'd3: y = a3;
      default: y = a0;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: searches req starting at (last+1) mod 4 and
// returns the first requester found; win holds last when nothing is requested.
module rr_pick_4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  src_t             last,
  output logic             any,
  output src_t             win
);

  src_t idx;

  always_comb begin
    any = 1'b0;
    win = last;
    idx = last;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = src_t'(32'(last) + k);
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter driving a single registered valid/ready output.
// state | meaning
// EMPTY | no word held, out_valid=0, any request is captured
// FULL  | word held in out_data/out_src, replaced only when popped
module rr_mux_arbiter_4
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [N_REQ-1:0] grant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output src_t             out_src
);

  state_t           state;
  src_t             last;
  src_t             win;
  logic             any;
  logic             load;
  logic             capture;
  logic [WIDTH-1:0] sel_data;

  rr_pick_4 u_pick (
    .req  (req),
    .last (last),
    .any  (any),
    .win  (win)
  );

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .sel (win),
    .a0  (d0),
    .a1  (d1),
    .a2  (d2),
    .a3  (d3),
    .y   (sel_data)
  );

  // rst gating keeps grant quiet for the whole reset window, not just after the edge
  assign load    = (state == EMPTY) | (out_valid & out_ready);
  assign capture = load & any & ~rst;
  assign grant   = capture ? onehot4(win) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      last      <= src_t'(N_REQ - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (capture) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_src   <= win;
            last      <= win;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (capture) begin
              out_data <= sel_data;
              out_src  <= win;
              last     <= win;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4 with hand-computed grants and output words.
module tb_rr_mux_arbiter_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] grant;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_src;

  int checks = 0;
  int failures = 0;

  rr_mux_arbiter_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] s);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_src"}, 32'(out_src), 32'(s));
  endtask

  // all-request rotation starting after requester 0: 1,2,3,0,1,2,3,0
  logic [1:0] rot_win [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rot_req [5] = '{4'b1011, 4'b1111, 4'b0001, 4'b0000, 4'b1110};

  initial begin
    rst = 1'b1; req = '0; out_ready = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    chk_out("rst", 1'b0, 4'h0, 2'd0);
    rst = 1'b0;

    // single requester 0 from reset
    req = 4'b0001; d0 = 4'hA; out_ready = 1'b1;
    #1 check("t1_grant", 32'(grant), 32'b0001);
    step();
    chk_out("t1", 1'b1, 4'hA, 2'd0);

    // pop with nothing requested -> empty, no grant
    req = 4'b0000;
    #1 check("t5_grant", 32'(grant), 32'h0);
    step();
    check("t5_valid", 32'(out_valid), 32'h0);

    // all four requesting, last=0 so rotation starts at 1
    req = 4'b1111; d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("rot%0d_grant", k), 32'(grant), 32'(4'b0001 << rot_win[k]));
      step();
      chk_out($sformatf("rot%0d", k), 1'b1, 4'(rot_win[k] + 2'd1), rot_win[k]);
    end

    // capture d2 then hold under back-pressure
    req = 4'b0100; d2 = 4'h5;
    #1 check("bp_cap_grant", 32'(grant), 32'b0100);
    step();
    chk_out("bp_cap", 1'b1, 4'h5, 2'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req = rot_req[k]; d2 = 4'(k + 8);
      #1 check($sformatf("bp%0d_grant", k), 32'(grant), 32'h0);
      step();
      chk_out($sformatf("bp%0d", k), 1'b1, 4'h5, 2'd2);
    end
    // release: pop and capture same edge, last=2 -> search 3,0,1,2
    out_ready = 1'b1; req = 4'b1011; d3 = 4'h7;
    #1 check("bp_rel_grant", 32'(grant), 32'b1000);
    step();
    chk_out("bp_rel", 1'b1, 4'h7, 2'd3);

    // grant 1, then 0 and 1 requesting -> 0 wins (search 2,3,0,1)
    req = 4'b0010; d1 = 4'h9;
    #1 check("l1_grant", 32'(grant), 32'b0010);
    step();
    chk_out("l1", 1'b1, 4'h9, 2'd1);
    req = 4'b0011; d0 = 4'h6;
    #1 check("l1b_grant", 32'(grant), 32'b0001);
    step();
    chk_out("l1b", 1'b1, 4'h6, 2'd0);

    // async reset while FULL
    req = 4'b1111; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check("ar_grant", 32'(grant), 32'h0);
    chk_out("ar", 1'b0, 4'h0, 2'd0);
    out_ready = 1'b1;
    step();
    check("ar_hold_grant", 32'(grant), 32'h0);
    check("ar_hold_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    req = 4'b1000; d3 = 4'hC;
    #1 check("ar3_grant", 32'(grant), 32'b1000);
    step();
    chk_out("ar3", 1'b1, 4'hC, 2'd3);
    req = 4'b1001; d0 = 4'hD;
    #1 check("ar0_grant", 32'(grant), 32'b0001);
    step();
    chk_out("ar0", 1'b1, 4'hD, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
